// File: rtl/arbitro_pc.sv
// arbitro_pc: arbitrates PC-update requests into one registered PC write with a post-write settle wait
module arbitro_pc #(
  parameter int unsigned LARGURA = 32,
  parameter logic [LARGURA-1:0] VETOR_EXCECAO = 32'h000000FF,
  parameter int unsigned ESPERA_CICLOS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_inc,
  input  logic               req_desvio,
  input  logic               cond_zero,
  input  logic               req_salto,
  input  logic               req_excecao,
  input  logic [LARGURA-1:0] pc_mais4,
  input  logic [LARGURA-1:0] alvo_desvio,
  input  logic [LARGURA-1:0] alvo_salto,
  output logic               pc_escrita,
  output logic [LARGURA-1:0] pc_novo,
  output logic [1:0]         pc_fonte,
  output logic               ack,
  output logic               ocupado
);
  typedef enum logic [1:0] {LIVRE, ESCREVE, ESPERA} estado_t;
  estado_t estado, estado_prox;
  logic [2:0] cnt, cnt_prox;
  logic pendente, pendente_prox;
  logic [LARGURA-1:0] novo_prox;
  logic [1:0] fonte_prox;
  logic exc, pedido;
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= LIVRE;
      cnt      <= '0;
      pendente <= 1'b0;
      pc_novo  <= '0;
      pc_fonte <= '0;
    end else begin
      estado   <= estado_prox;
      cnt      <= cnt_prox;
      pendente <= pendente_prox;
      pc_novo  <= novo_prox;
      pc_fonte <= fonte_prox;
    end
  end
  always_comb begin
    exc = req_excecao | pendente;
    pedido = exc | req_salto | req_desvio | req_inc;
    estado_prox = estado;
    cnt_prox = cnt;
    pendente_prox = pendente;
    novo_prox = pc_novo;
    fonte_prox = pc_fonte;
    case (estado)
      LIVRE: if (pedido) begin
        estado_prox = ESCREVE;
        pendente_prox = 1'b0;
        fonte_prox = exc ? 2'd3 : req_salto ? 2'd2 : (req_desvio && cond_zero) ? 2'd1 : 2'd0;
        novo_prox = exc ? VETOR_EXCECAO : req_salto ? alvo_salto :
                    (req_desvio && cond_zero) ? alvo_desvio : pc_mais4;
      end
      ESCREVE: begin
        pendente_prox = pendente | req_excecao;
        estado_prox = (ESPERA_CICLOS == 0) ? LIVRE : ESPERA;
        cnt_prox = 3'(ESPERA_CICLOS);
      end
      ESPERA: begin
        pendente_prox = pendente | req_excecao;
        cnt_prox = cnt - 3'd1;
        estado_prox = (cnt <= 3'd1) ? LIVRE : ESPERA;
      end
      default: estado_prox = LIVRE;
    endcase
  end
  assign pc_escrita = (estado == ESCREVE);
  assign ack = (estado == ESCREVE);
  assign ocupado = (estado != LIVRE);
endmodule

// File: tb/tb_arbitro_pc.sv
// tb_arbitro_pc: scoreboard bench for arbitro_pc (default wait and zero-wait instances)
module tb_arbitro_pc;
  typedef struct packed {logic [31:0] novo; logic [1:0] fonte;} esperado_t;
  logic clk = 0, reset = 1;
  logic req_inc = 0, req_desvio = 0, cond_zero = 0, req_salto = 0, req_excecao = 0;
  logic [31:0] pc_mais4 = 0, alvo_desvio = 0, alvo_salto = 0;
  logic pc_escrita, ack, ocupado;
  logic [31:0] pc_novo;
  logic [1:0] pc_fonte;
  logic req_inc_b = 0, zero_b = 0;
  logic [31:0] pc_mais4_b = 32'h44, nulo_b = 0;
  logic pc_escrita_b, ack_b, ocupado_b;
  logic [31:0] pc_novo_b;
  logic [1:0] pc_fonte_b;
  esperado_t fila[$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  arbitro_pc dut (
    .clk(clk), .reset(reset), .req_inc(req_inc), .req_desvio(req_desvio), .cond_zero(cond_zero),
    .req_salto(req_salto), .req_excecao(req_excecao), .pc_mais4(pc_mais4), .alvo_desvio(alvo_desvio),
    .alvo_salto(alvo_salto), .pc_escrita(pc_escrita), .pc_novo(pc_novo), .pc_fonte(pc_fonte),
    .ack(ack), .ocupado(ocupado)
  );
  arbitro_pc #(.ESPERA_CICLOS(0)) dut_b (
    .clk(clk), .reset(reset), .req_inc(req_inc_b), .req_desvio(zero_b), .cond_zero(zero_b),
    .req_salto(zero_b), .req_excecao(zero_b), .pc_mais4(pc_mais4_b), .alvo_desvio(nulo_b),
    .alvo_salto(nulo_b), .pc_escrita(pc_escrita_b), .pc_novo(pc_novo_b), .pc_fonte(pc_fonte_b),
    .ack(ack_b), .ocupado(ocupado_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (pc_escrita) begin
      if (fila.size() == 0) chk("escrita_inesperada", 32'(pc_escrita), 0);
      else begin
        automatic esperado_t e = fila.pop_front();
        chk("pc_novo", pc_novo, e.novo);
        chk("pc_fonte", 32'(pc_fonte), 32'(e.fonte));
        chk("ack", 32'(ack), 1);
      end
    end else if (ack) chk("ack_sem_escrita", 32'(ack), 0);
  end
  task automatic aguarda_ack(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
  endtask
  task automatic aguarda_livre;
    int n = 0;
    do begin @(negedge clk); n++; end while (ocupado && n < 20);
    chk("livre", 32'(ocupado), 0);
  endtask
  initial begin
    int lat, c;
    logic [7:0] padrao;
    repeat (2) @(negedge clk);
    chk("rst_escrita", 32'(pc_escrita), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_novo", pc_novo, 0);
    chk("rst_fonte", 32'(pc_fonte), 0);
    reset = 0;
    @(negedge clk);
    chk("ocioso", 32'(ocupado), 0);
    req_inc = 1; pc_mais4 = 32'h4;
    fila.push_back('{32'h4, 2'd0});
    aguarda_ack(lat);
    chk("inc_lat", lat, 1);
    req_inc = 0;
    c = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ocupado) break;
      c++;
    end
    chk("ocupado_ciclos", c, 3);
    req_salto = 1; req_desvio = 1; cond_zero = 1; req_inc = 1;
    alvo_salto = 32'h100; alvo_desvio = 32'h200; pc_mais4 = 32'h8;
    fila.push_back('{32'h100, 2'd2});
    aguarda_ack(lat);
    chk("salto_lat", lat, 1);
    req_salto = 0;
    fila.push_back('{32'h200, 2'd1});
    aguarda_ack(lat);
    chk("desvio_lat", lat, 4);
    req_desvio = 0;
    fila.push_back('{32'h8, 2'd0});
    aguarda_ack(lat);
    chk("inc_perdedor_lat", lat, 4);
    req_inc = 0; cond_zero = 0;
    aguarda_livre();
    req_desvio = 1; cond_zero = 0; pc_mais4 = 32'h20; alvo_desvio = 32'h80;
    fila.push_back('{32'h20, 2'd0});
    aguarda_ack(lat);
    chk("desvio_nt_lat", lat, 1);
    req_desvio = 0;
    aguarda_livre();
    req_inc = 1; pc_mais4 = 32'h30;
    fila.push_back('{32'h30, 2'd0});
    aguarda_ack(lat);
    req_inc = 0;
    @(negedge clk);
    chk("exc_durante_ocupado", 32'(ocupado), 1);
    req_excecao = 1; req_inc = 1; pc_mais4 = 32'h34;
    fila.push_back('{32'hFF, 2'd3});
    @(negedge clk);
    req_excecao = 0;
    aguarda_ack(lat);
    chk("exc_pend_lat", lat, 2);
    fila.push_back('{32'h34, 2'd0});
    aguarda_ack(lat);
    chk("inc_pos_exc_lat", lat, 4);
    req_inc = 0;
    @(negedge clk);
    chk("retem_novo", pc_novo, 32'h34);
    chk("retem_sem_escrita", 32'(pc_escrita), 0);
    aguarda_livre();
    req_inc = 1; pc_mais4 = 32'h40;
    fila.push_back('{32'h40, 2'd0});
    aguarda_ack(lat);
    chk("pre_reset_lat", lat, 1);
    req_inc = 0;
    @(negedge clk);
    req_excecao = 1;
    @(negedge clk);
    req_excecao = 0; reset = 1;
    chk("reset_em_espera", 32'(ocupado), 1);
    @(negedge clk);
    chk("abort_escrita", 32'(pc_escrita), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_ocupado", 32'(ocupado), 0);
    chk("abort_novo", pc_novo, 0);
    chk("abort_fonte", 32'(pc_fonte), 0);
    reset = 0;
    c = 0;
    repeat (10) begin @(negedge clk); c += int'(pc_escrita); end
    chk("sem_escrita_pos_reset", c, 0);
    req_inc_b = 1;
    padrao = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      padrao[i] = pc_escrita_b;
      if (i == 0) chk("b_novo", pc_novo_b, 32'h44);
    end
    chk("b_padrao", 32'(padrao), 32'h55);
    req_inc_b = 0;
    chk("sb_vazia", fila.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/arbitro_pc.md
ARBITRO_PC -- requirements
Module: arbitro_pc

Interface
REQ-001 The block SHALL have parameter LARGURA, default 32, giving the PC/address width in bits.
REQ-002 The block SHALL have parameter VETOR_EXCECAO, default 32'h000000FF, giving the exception handler address.
REQ-003 The block SHALL have parameter ESPERA_CICLOS, default 2, range 0..7, giving the post-write wait cycles (memory settle).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 req_inc  input  1  request PC <= pc_mais4.
REQ-007 req_desvio  input  1  conditional branch request.
REQ-008 cond_zero  input  1  ALU zero flag; branch taken when 1.
REQ-009 req_salto  input  1  unconditional jump request.
REQ-010 req_excecao  input  1  exception request.
REQ-011 pc_mais4, alvo_desvio, alvo_salto  input  LARGURA each  candidate PC values.
REQ-012 pc_escrita  output  1  PC register write enable.
REQ-013 pc_novo  output  LARGURA  value to load into PC.
REQ-014 pc_fonte  output  2  granted source: 0 inc, 1 desvio taken, 2 salto, 3 excecao.
REQ-015 ack  output  1  one-cycle grant acknowledge.
REQ-016 ocupado  output  1  arbiter busy; requests not sampled.

Function
REQ-017 The block SHALL implement states LIVRE, ESCREVE, ESPERA.
REQ-018 In LIVRE, the block SHALL sample requests each cycle; with none active (and no pending exception) it SHALL remain in LIVRE.
REQ-019 Priority SHALL be: excecao (or pending exception) > salto > desvio > inc.
REQ-020 A granted desvio with cond_zero=1 SHALL select alvo_desvio, pc_fonte=1; with cond_zero=0 it SHALL select pc_mais4, pc_fonte=0.
REQ-021 A granted excecao SHALL select VETOR_EXCECAO, pc_fonte=3; salto SHALL select alvo_salto, pc_fonte=2; inc SHALL select pc_mais4, pc_fonte=0.
REQ-022 On a grant in LIVRE, pc_novo and pc_fonte SHALL be registered and the FSM SHALL enter ESCREVE next cycle (latency 1 cycle from request to pc_escrita).
REQ-023 In ESCREVE, pc_escrita=1 and ack=1 for exactly one cycle; both SHALL be 0 in every other state.
REQ-024 From ESCREVE, the FSM SHALL go to ESPERA loaded with ESPERA_CICLOS, or directly to LIVRE if ESPERA_CICLOS=0.
REQ-025 In ESPERA, a counter SHALL decrement each cycle; on reaching 1 the FSM SHALL return to LIVRE (ESPERA lasts exactly ESPERA_CICLOS cycles).
REQ-026 ocupado SHALL be 1 in ESCREVE and ESPERA, 0 in LIVRE.
REQ-027 Non-exception requesters SHALL hold their request until ack; requests asserted while ocupado=1 SHALL be ignored.
REQ-028 req_excecao asserted while ocupado=1 SHALL set a pending flag that persists after req_excecao deasserts and SHALL be served on the first LIVRE cycle, then cleared at the grant.
REQ-029 pc_novo and pc_fonte SHALL hold their last granted values until the next grant.
REQ-030 Simultaneous requests SHALL produce exactly one grant per ESCREVE; losers are served only if still asserted in a later LIVRE cycle.

Reset
REQ-031 reset=1 SHALL force state LIVRE, counter 0, pending flag 0, pc_escrita=0, ack=0, ocupado=0, pc_fonte=0, pc_novo=0 at the next rising edge, regardless of current state.
REQ-032 reset asserted in ESCREVE or ESPERA SHALL abort the operation; no pc_escrita pulse SHALL follow reset deassertion without a new request.

Verification
REQ-033 req_inc=1, pc_mais4=32'h4 in LIVRE -> next cycle pc_escrita=1, ack=1, pc_novo=32'h4, pc_fonte=0; ocupado=1 for 3 cycles (ESPERA_CICLOS=2).
REQ-034 req_salto=1, req_desvio=1, cond_zero=1, req_inc=1 same cycle -> pc_fonte=2, pc_novo=alvo_salto; desvio served only after ocupado falls, still holding.
REQ-035 req_desvio=1, cond_zero=0, pc_mais4=32'h20, alvo_desvio=32'h80 -> pc_novo=32'h20, pc_fonte=0.
REQ-036 req_excecao pulsed 1 cycle during ESPERA -> after return to LIVRE, pc_novo=32'hFF, pc_fonte=3, ack=1, despite req_inc=1 also active.
REQ-037 reset=1 for 1 cycle while in ESPERA with pending exception -> all outputs 0, no pc_escrita afterwards with all requests 0.
REQ-038 ESPERA_CICLOS=0, req_inc held continuously -> pc_escrita pulses every 2nd cycle.
